// File: rtl/vga_timing_monitor_if.sv
`default_nettype none
// ============================================================================
// Interface : vga_timing_monitor_if
// Brief     : Video sample inputs and status outputs of the VGA timing monitor.
// Revision  : 1.0
// ============================================================================
interface vga_timing_monitor_if;
   logic        enable;
   logic        pix_en;
   logic        h_sync;
   logic        v_sync;
   logic        blank_n;
   logic        locked;
   logic        done;
   logic        error;
   logic [2:0]  err_code;
   logic [15:0] frame_count;

   modport master (
      output enable, pix_en, h_sync, v_sync, blank_n,
      input  locked, done, error, err_code, frame_count
   );

   modport slave (
      input  enable, pix_en, h_sync, v_sync, blank_n,
      output locked, done, error, err_code, frame_count
   );
endinterface
`default_nettype wire

// File: rtl/vga_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_monitor
// Brief    : Measures VGA sync/blank timing at each pixel strobe and reports
//            lock, completion after FRAMES_REQ clean frames, or the first error.
// Revision : 1.0
// ============================================================================
module vga_timing_monitor #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_POL   = 0,
   parameter int FRAMES_REQ = 2
) (
   input  wire logic           clk,
   input  wire logic           reset,
   vga_timing_monitor_if.slave mon
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int PW      = $clog2(2 * H_TOTAL + 1);
   localparam int LW      = $clog2(V_TOTAL + 2);

   localparam logic [PW-1:0] H_TOTAL_P  = PW'(H_TOTAL);
   localparam logic [PW-1:0] H_SYNC_P   = PW'(H_SYNC);
   localparam logic [PW-1:0] H_ACTIVE_P = PW'(H_ACTIVE);
   localparam logic [PW-1:0] TIMEOUT_P  = PW'(2 * H_TOTAL);
   localparam logic [PW-1:0] P_ONE      = PW'(1);
   localparam logic [LW-1:0] V_TOTAL_L  = LW'(V_TOTAL);
   localparam logic [LW-1:0] V_ACTIVE_L = LW'(V_ACTIVE);
   localparam logic [LW-1:0] V_SYNC_L   = LW'(V_SYNC);
   localparam logic [LW-1:0] L_ONE      = LW'(1);
   localparam logic          SYNC_LVL   = (SYNC_POL != 0);
   localparam logic [16:0]   FRAMES_W   = 17'(FRAMES_REQ);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEEK    = 3'd1,
      ST_ALIGN   = 3'd2,
      ST_MEASURE = 3'd3,
      ST_PASS    = 3'd4,
      ST_FAIL    = 3'd5
   } state_t;

   state_t        state;
   state_t        state_next;
   logic          hs_prev;
   logic          vs_prev;
   logic [PW-1:0] pix_cnt;
   logic [PW-1:0] hs_w;
   logic [PW-1:0] act_px;
   logic [LW-1:0] line_cnt;
   logic [LW-1:0] act_lines;
   logic [LW-1:0] vs_w;

   logic          hs_act;
   logic          vs_act;
   logic          hs_lead;
   logic          hs_trail;
   logic          vs_lead;
   logic          vs_trail;
   logic          measuring;
   logic          checking;
   logic          align_entry;
   logic          frame_clean;
   logic [2:0]    viol_code;
   logic [16:0]   frame_inc;

   assign hs_act    = (mon.h_sync == SYNC_LVL);
   assign vs_act    = (mon.v_sync == SYNC_LVL);
   assign hs_lead   = mon.pix_en &  hs_act & ~hs_prev;
   assign hs_trail  = mon.pix_en & ~hs_act &  hs_prev;
   assign vs_lead   = mon.pix_en &  vs_act & ~vs_prev;
   assign vs_trail  = mon.pix_en & ~vs_act &  vs_prev;
   assign measuring = (state == ST_MEASURE);
   assign checking  = (state == ST_ALIGN) || (state == ST_MEASURE);
   assign frame_inc = {1'b0, mon.frame_count} + 17'd1;

   // Later assignments override earlier ones, so the lowest code wins.
   always_comb begin
      viol_code = 3'd0;
      if (checking && mon.pix_en && (pix_cnt >= TIMEOUT_P))
         viol_code = 3'd6;
      if (measuring && vs_trail && (vs_w != V_SYNC_L))
         viol_code = 3'd5;
      if (measuring && vs_lead && ((line_cnt != V_TOTAL_L) || (act_lines != V_ACTIVE_L)))
         viol_code = 3'd4;
      if (measuring && hs_lead && (act_px != H_ACTIVE_P) && (act_px != '0))
         viol_code = 3'd3;
      if (measuring && hs_trail && (hs_w != H_SYNC_P))
         viol_code = 3'd2;
      if (measuring && hs_lead && (pix_cnt != H_TOTAL_P))
         viol_code = 3'd1;
   end

   always_comb begin
      state_next  = state;
      align_entry = 1'b0;
      frame_clean = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mon.enable)
               state_next = ST_SEEK;
         end
         ST_SEEK: begin
            if (vs_lead) begin
               state_next  = ST_ALIGN;
               align_entry = 1'b1;
            end
         end
         ST_ALIGN: begin
            if (viol_code != 3'd0)
               state_next = ST_FAIL;
            else if (hs_lead)
               state_next = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (viol_code != 3'd0) begin
               state_next = ST_FAIL;
            end else if (vs_lead) begin
               frame_clean = 1'b1;
               if (frame_inc >= FRAMES_W)
                  state_next = ST_PASS;
            end
         end
         default: begin
            state_next = state;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || !mon.enable) begin
         state           <= ST_IDLE;
         hs_prev         <= 1'b0;
         vs_prev         <= 1'b0;
         pix_cnt         <= '0;
         hs_w            <= '0;
         act_px          <= '0;
         line_cnt        <= '0;
         act_lines       <= '0;
         vs_w            <= '0;
         mon.locked      <= 1'b0;
         mon.done        <= 1'b0;
         mon.error       <= 1'b0;
         mon.err_code    <= 3'd0;
         mon.frame_count <= 16'd0;
      end else begin
         state <= state_next;
         if (mon.pix_en) begin
            hs_prev <= hs_act;
            vs_prev <= vs_act;
            if (align_entry) begin
               pix_cnt   <= '0;
               hs_w      <= '0;
               act_px    <= '0;
               line_cnt  <= '0;
               act_lines <= '0;
               vs_w      <= '0;
            end else begin
               // A leading hsync edge is the first sample of the next line.
               pix_cnt <= hs_lead ? P_ONE :
                          ((pix_cnt == '1) ? pix_cnt : pix_cnt + P_ONE);
               hs_w    <= hs_lead ? P_ONE :
                          (!hs_act ? '0 : ((hs_w == '1) ? hs_w : hs_w + P_ONE));
               act_px  <= hs_lead ? PW'(mon.blank_n) :
                          ((act_px == '1) ? act_px : act_px + PW'(mon.blank_n));
               if (vs_lead)
                  act_lines <= '0;
               else if (hs_lead && (act_px == H_ACTIVE_P) && (act_lines != '1))
                  act_lines <= act_lines + L_ONE;
               if (vs_lead)
                  line_cnt <= '0;
               else if (hs_lead && (line_cnt != '1))
                  line_cnt <= line_cnt + L_ONE;
               if (vs_lead)
                  vs_w <= '0;
               else if (hs_lead && vs_act && (vs_w != '1))
                  vs_w <= vs_w + L_ONE;
            end
         end
         if ((state_next == ST_FAIL) && (state != ST_FAIL)) begin
            mon.error    <= 1'b1;
            mon.err_code <= viol_code;
            mon.locked   <= 1'b0;
            mon.done     <= 1'b0;
         end else if (frame_clean) begin
            mon.locked <= 1'b1;
            if (mon.frame_count != 16'hFFFF)
               mon.frame_count <= frame_inc[15:0];
            if (state_next == ST_PASS)
               mon.done <= 1'b1;
         end
      end
   end
endmodule
`default_nettype wire
